// File: rtl/intersection_phase_scheduler_if.sv
// ---------------------------------------------------------------------------
// intersection_phase_scheduler_if : approach handshake and preemption bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface intersection_phase_scheduler_if;
  logic [3:0] done_i;
  logic [3:0] demand_i;
  logic       preempt_i;
  logic [1:0] preempt_dir_i;
  logic [3:0] enable_o;
  logic [3:0] clear_o;
  logic       all_red_o;
  logic [1:0] phase_o;
  logic       preempt_active_o;

  modport master (
    output done_i, demand_i, preempt_i, preempt_dir_i,
    input  enable_o, clear_o, all_red_o, phase_o, preempt_active_o
  );

  modport slave (
    input  done_i, demand_i, preempt_i, preempt_dir_i,
    output enable_o, clear_o, all_red_o, phase_o, preempt_active_o
  );
endinterface

`default_nettype wire

// File: rtl/intersection_phase_scheduler.sv
// ---------------------------------------------------------------------------
// intersection_phase_scheduler : one-green-at-a-time approach sequencer with
// timed all-red clearance, demand round-robin and emergency preemption.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module intersection_phase_scheduler #(
  parameter int DIV_FACTOR  = 1000,
  parameter int ALL_RED_SEC = 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  intersection_phase_scheduler_if.slave bus
);

  localparam int PW = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;
  localparam int SW = (ALL_RED_SEC > 1) ? $clog2(ALL_RED_SEC + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV_FACTOR - 1);
  localparam logic [SW-1:0] SEC_LAST   = SW'(ALL_RED_SEC - 1);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [SW-1:0] secs, secs_n;
  logic [3:0]    enable, enable_n;
  logic [3:0]    clear, clear_n;
  logic          all_red, all_red_n;
  logic [1:0]    phase, phase_n;
  logic          pact, pact_n;

  logic [1:0]    sel;
  logic          found;
  logic [1:0]    cand;

  // Preemption wins; otherwise scan demand starting just after the last phase.
  always_comb begin
    sel   = phase + 2'd1;
    found = 1'b0;
    cand  = 2'd0;
    if (bus.preempt_i) begin
      sel = bus.preempt_dir_i;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        cand = phase + k[1:0];
        if (!found && bus.demand_i[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n   = state;
    presc_n   = presc;
    secs_n    = secs;
    enable_n  = enable;
    clear_n   = '0;
    all_red_n = all_red;
    phase_n   = phase;
    pact_n    = pact;
    case (state)
      CLEAR: begin
        enable_n  = '0;
        all_red_n = 1'b1;
        if (presc == PRESC_LAST) begin
          presc_n = '0;
          if (secs == SEC_LAST) begin
            secs_n    = '0;
            state_n   = GRANT;
            clear_n   = 4'b0001 << sel;
            phase_n   = sel;
            all_red_n = 1'b0;
            pact_n    = bus.preempt_i;
          end else begin
            secs_n = secs + SW'(1);
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      GRANT: begin
        enable_n = 4'b0001 << phase;
        state_n  = RUN;
      end
      RUN: begin
        pact_n = 1'b0;
        if (bus.preempt_i && (bus.preempt_dir_i == phase)) begin
          pact_n = 1'b1;
        end else if (bus.preempt_i || bus.done_i[phase]) begin
          // Foreign preemption aborts the green; the held-green case above masks done.
          enable_n  = '0;
          all_red_n = 1'b1;
          state_n   = CLEAR;
          presc_n   = '0;
          secs_n    = '0;
        end
      end
      default: begin
        state_n   = CLEAR;
        enable_n  = '0;
        all_red_n = 1'b1;
        presc_n   = '0;
        secs_n    = '0;
        pact_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      presc   <= '0;
      secs    <= '0;
      enable  <= '0;
      clear   <= '0;
      all_red <= 1'b1;
      phase   <= 2'd3;
      pact    <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      secs    <= secs_n;
      enable  <= enable_n;
      clear   <= clear_n;
      all_red <= all_red_n;
      phase   <= phase_n;
      pact    <= pact_n;
    end
  end

  assign bus.enable_o         = enable;
  assign bus.clear_o          = clear;
  assign bus.all_red_o        = all_red;
  assign bus.phase_o          = phase;
  assign bus.preempt_active_o = pact;

endmodule

`default_nettype wire

// File: tb/tb_intersection_phase_scheduler.sv
// ---------------------------------------------------------------------------
// tb_intersection_phase_scheduler : directed scenarios with DIV_FACTOR=4,
// ALL_RED_SEC=2 (8-cycle clearance).
// ---------------------------------------------------------------------------
`default_nettype none

module tb_intersection_phase_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc;
  int   bad;

  intersection_phase_scheduler_if bus ();

  intersection_phase_scheduler #(
    .DIV_FACTOR (4),
    .ALL_RED_SEC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for a clear pulse, counting CLEAR cycles that were not all-red.
  task automatic wait_grant(output int cycles, output int badc);
    cycles = 0;
    badc   = 0;
    while (bus.clear_o == 4'b0000 && cycles < 40) begin
      if (bus.all_red_o !== 1'b1 || bus.enable_o !== 4'b0000) badc++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    bus.done_i = 4'b0000; bus.demand_i = 4'hF;
    bus.preempt_i = 1'b0; bus.preempt_dir_i = 2'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.enable_o !== 4'b0000) begin failures++; $display("FAIL rst_enable got=%b exp=0000", bus.enable_o); end
    checks++; if (bus.clear_o !== 4'b0000) begin failures++; $display("FAIL rst_clear got=%b exp=0000", bus.clear_o); end
    checks++; if (bus.all_red_o !== 1'b1) begin failures++; $display("FAIL rst_all_red got=%b exp=1", bus.all_red_o); end
    checks++; if (bus.phase_o !== 2'd3) begin failures++; $display("FAIL rst_phase got=%0d exp=3", bus.phase_o); end
    checks++; if (bus.preempt_active_o !== 1'b0) begin failures++; $display("FAIL rst_pact got=%b exp=0", bus.preempt_active_o); end
    rst = 1'b0;
  endtask

  task automatic test_first_grant();
    wait_grant(cyc, bad);
    checks++; if (cyc != 8 || bad != 0) begin failures++; $display("FAIL first_clear_len got=%0d bad=%0d exp=8 bad=0", cyc, bad); end
    checks++; if (bus.clear_o !== 4'b0001 || bus.phase_o !== 2'd0 || bus.all_red_o !== 1'b0) begin
      failures++; $display("FAIL first_grant clear=%b phase=%0d all_red=%b exp 0001/0/0", bus.clear_o, bus.phase_o, bus.all_red_o); end
    @(negedge clk);
    checks++; if (bus.enable_o !== 4'b0001 || bus.clear_o !== 4'b0000) begin
      failures++; $display("FAIL first_run enable=%b clear=%b exp 0001/0000", bus.enable_o, bus.clear_o); end
  endtask

  task automatic test_done_handoff();
    bus.done_i = 4'b1110;
    repeat (3) @(negedge clk);
    checks++; if (bus.enable_o !== 4'b0001 || bus.all_red_o !== 1'b0) begin
      failures++; $display("FAIL foreign_done enable=%b all_red=%b exp 0001/0", bus.enable_o, bus.all_red_o); end
    bus.done_i = 4'b0001;
    @(negedge clk);
    checks++; if (bus.enable_o !== 4'b0000 || bus.all_red_o !== 1'b1) begin
      failures++; $display("FAIL done_drop enable=%b all_red=%b exp 0000/1", bus.enable_o, bus.all_red_o); end
    bus.done_i = 4'b0000;
    wait_grant(cyc, bad);
    checks++; if (cyc != 8 || bad != 0) begin failures++; $display("FAIL handoff_clear_len got=%0d bad=%0d exp=8 bad=0", cyc, bad); end
    checks++; if (bus.clear_o !== 4'b0010 || bus.phase_o !== 2'd1) begin
      failures++; $display("FAIL handoff_grant clear=%b phase=%0d exp 0010/1", bus.clear_o, bus.phase_o); end
    @(negedge clk);
    checks++; if (bus.enable_o !== 4'b0010) begin failures++; $display("FAIL handoff_run enable=%b exp 0010", bus.enable_o); end
  endtask

  task automatic test_skip_wrap();
    bus.demand_i = 4'b1000;
    bus.done_i   = 4'b0010;
    @(negedge clk);
    bus.done_i = 4'b0000;
    wait_grant(cyc, bad);
    checks++; if (bus.clear_o !== 4'b1000 || bus.phase_o !== 2'd3 || cyc != 8) begin
      failures++; $display("FAIL skip_grant clear=%b phase=%0d cyc=%0d exp 1000/3/8", bus.clear_o, bus.phase_o, cyc); end
    @(negedge clk);
    bus.demand_i = 4'b1001;
    bus.done_i   = 4'b1000;
    @(negedge clk);
    bus.done_i = 4'b0000;
    wait_grant(cyc, bad);
    checks++; if (bus.clear_o !== 4'b0001 || bus.phase_o !== 2'd0) begin
      failures++; $display("FAIL wrap_grant clear=%b phase=%0d exp 0001/0", bus.clear_o, bus.phase_o); end
    @(negedge clk);
    checks++; if (bus.enable_o !== 4'b0001) begin failures++; $display("FAIL wrap_run enable=%b exp 0001", bus.enable_o); end
  endtask

  task automatic test_preempt();
    bus.preempt_i = 1'b1; bus.preempt_dir_i = 2'd2;
    @(negedge clk);
    checks++; if (bus.enable_o !== 4'b0000 || bus.all_red_o !== 1'b1) begin
      failures++; $display("FAIL preempt_abort enable=%b all_red=%b exp 0000/1", bus.enable_o, bus.all_red_o); end
    wait_grant(cyc, bad);
    checks++; if (cyc != 8 || bad != 0 || bus.clear_o !== 4'b0100 || bus.preempt_active_o !== 1'b1) begin
      failures++; $display("FAIL preempt_grant cyc=%0d bad=%0d clear=%b pact=%b exp 8/0/0100/1", cyc, bad, bus.clear_o, bus.preempt_active_o); end
    @(negedge clk);
    bus.done_i = 4'b0100;
    repeat (3) @(negedge clk);
    checks++; if (bus.enable_o !== 4'b0100 || bus.preempt_active_o !== 1'b1) begin
      failures++; $display("FAIL preempt_hold enable=%b pact=%b exp 0100/1", bus.enable_o, bus.preempt_active_o); end
    bus.preempt_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.enable_o !== 4'b0000 || bus.preempt_active_o !== 1'b0 || bus.all_red_o !== 1'b1) begin
      failures++; $display("FAIL preempt_release enable=%b pact=%b all_red=%b exp 0000/0/1", bus.enable_o, bus.preempt_active_o, bus.all_red_o); end
    bus.done_i = 4'b0000;
  endtask

  task automatic test_back_to_back();
    bus.demand_i = 4'b0001;
    wait_grant(cyc, bad);
    checks++; if (bus.clear_o !== 4'b0001 || cyc != 8) begin
      failures++; $display("FAIL b2b_first clear=%b cyc=%0d exp 0001/8", bus.clear_o, cyc); end
    @(negedge clk);
    bus.done_i = 4'b0001; bus.preempt_i = 1'b1; bus.preempt_dir_i = 2'd3;
    @(negedge clk);
    checks++; if (bus.enable_o !== 4'b0000 || bus.all_red_o !== 1'b1) begin
      failures++; $display("FAIL b2b_drop enable=%b all_red=%b exp 0000/1", bus.enable_o, bus.all_red_o); end
    bus.done_i = 4'b0000;
    wait_grant(cyc, bad);
    checks++; if (bus.clear_o !== 4'b1000 || bus.phase_o !== 2'd3 || bus.preempt_active_o !== 1'b1) begin
      failures++; $display("FAIL b2b_preempt clear=%b phase=%0d pact=%b exp 1000/3/1", bus.clear_o, bus.phase_o, bus.preempt_active_o); end
    @(negedge clk);
    checks++; if (bus.enable_o !== 4'b1000 || bus.preempt_active_o !== 1'b1) begin
      failures++; $display("FAIL b2b_run enable=%b pact=%b exp 1000/1", bus.enable_o, bus.preempt_active_o); end
    bus.preempt_i = 1'b0; bus.done_i = 4'b1000;
    @(negedge clk);
    checks++; if (bus.enable_o !== 4'b0000 || bus.preempt_active_o !== 1'b0) begin
      failures++; $display("FAIL b2b_end enable=%b pact=%b exp 0000/0", bus.enable_o, bus.preempt_active_o); end
    bus.done_i = 4'b0000;
  endtask

  task automatic test_fixed_cycle();
    logic [1:0] exp_ph;
    logic [3:0] exp_oh;
    bus.demand_i = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      exp_ph = k[1:0];
      exp_oh = 4'b0001 << exp_ph;
      wait_grant(cyc, bad);
      checks++; if (cyc != 8 || bad != 0 || bus.clear_o !== exp_oh || bus.phase_o !== exp_ph) begin
        failures++; $display("FAIL fixed_grant%0d cyc=%0d bad=%0d clear=%b phase=%0d exp 8/0/%b/%0d", k, cyc, bad, bus.clear_o, bus.phase_o, exp_oh, exp_ph); end
      @(negedge clk);
      checks++; if (bus.enable_o !== exp_oh) begin failures++; $display("FAIL fixed_run%0d enable=%b exp %b", k, bus.enable_o, exp_oh); end
      if (k < 4) begin
        bus.done_i = exp_oh;
        @(negedge clk);
        bus.done_i = 4'b0000;
      end
    end
  endtask

  task automatic test_mid_reset();
    bus.preempt_i = 1'b1; bus.preempt_dir_i = 2'd0;
    @(negedge clk);
    checks++; if (bus.preempt_active_o !== 1'b1 || bus.enable_o !== 4'b0001) begin
      failures++; $display("FAIL hold_before_rst pact=%b enable=%b exp 1/0001", bus.preempt_active_o, bus.enable_o); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.enable_o !== 4'b0000 || bus.all_red_o !== 1'b1 || bus.phase_o !== 2'd3 || bus.preempt_active_o !== 1'b0 || bus.clear_o !== 4'b0000) begin
      failures++; $display("FAIL mid_rst enable=%b all_red=%b phase=%0d pact=%b clear=%b exp 0000/1/3/0/0000",
                           bus.enable_o, bus.all_red_o, bus.phase_o, bus.preempt_active_o, bus.clear_o); end
    rst = 1'b0; bus.preempt_i = 1'b0; bus.demand_i = 4'hF;
    wait_grant(cyc, bad);
    checks++; if (cyc != 8 || bus.clear_o !== 4'b0001 || bus.phase_o !== 2'd0) begin
      failures++; $display("FAIL post_rst_grant cyc=%0d clear=%b phase=%0d exp 8/0001/0", cyc, bus.clear_o, bus.phase_o); end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_done_handoff();
    test_skip_wrap();
    test_preempt();
    test_back_to_back();
    test_fixed_cycle();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
